adder_mp_arbiter: RTL and testbench
===================================

Name: adder_mp_arbiter

Overview:
- Shares one W-bit carry-select adder datapath between two requesters.
- Each request is a multi-precision add streamed word by word, least-significant word first, with a last flag. The carry chains between words inside one transaction.
- A round-robin arbiter locks the adder to one requester until that requester's last word is accepted.
- Results leave through one registered valid/ready stream tagged with the requester id. The block sits between the issuing engines and the adder.

Parameters:
- W, 32, word width of operands and sum.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0_valid  input  1  requester 0 word valid.
- req0_ready  output  1  requester 0 word accepted this cycle when req0_valid is also high.
- req0_a  input  W  requester 0 operand A word.
- req0_b  input  W  requester 0 operand B word.
- req0_cin  input  1  carry-in; sampled only on the first word of a transaction.
- req0_last  input  1  marks the final word of the transaction.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin, req1_last  same directions, widths and meaning as the req0 signals, for requester 1.
- res_valid  output  1  result word valid.
- res_ready  input  1  downstream accepts the result word.
- res_sum  output  W  a + b + carry for the word.
- res_cout  output  1  carry-out of this word; on the last word it is the transaction carry-out.
- res_last  output  1  copy of last for this word.
- res_id  output  1  owning requester, 0 or 1.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE, grant to none, carry register to 0, round-robin pointer to favour requester 0.
  - res_valid=0, res_sum=0, res_cout=0, res_last=0, res_id=0; req0_ready=req1_ready=0.
  - Any partial transaction or buffered result is discarded, with no output for it.
- States are IDLE, ARB and BUSY.
  - IDLE: both readies are 0. If either reqX_valid is high, go to ARB.
  - ARB, one cycle: latch the owner.
    - If only one requester is valid, it wins.
    - If both are valid, the requester the pointer favours wins.
    - If neither is valid (a valid was withdrawn), return to IDLE.
    - On a grant, go to BUSY and set first_word=1.
  - BUSY:
    - Owner ready = (res_valid==0) || res_ready. The non-owner's ready is 0.
    - When the owner's word is accepted with last=1, go to IDLE and set the pointer to favour the other requester.
    - If the owner drops valid mid-transaction, the lock holds indefinitely. There is no timeout.
- Arithmetic per accepted word:
  - Carry in = reqX_cin if first_word, else the carry register.
  - {cout, sum} = a + b + carry in, computed at W+1 bits. Overflow wraps modulo 2^W in sum.
  - The carry register is loaded with cout, and first_word is cleared.
  - On a last word, the carry register is cleared and first_word is set.
- Output:
  - The result register loads on word acceptance. res_valid rises the cycle after acceptance, so latency is 1 cycle.
  - The register holds stable while res_valid && !res_ready.
  - Acceptance of a new word while the previous result drains in the same cycle (res_ready=1) is legal, giving a throughput of 1 word per cycle.
- Turnaround: after a last word, at least 2 cycles pass (IDLE, ARB) before any first word of the next transaction is accepted.
- A single-word transaction (last=1 on the first word) uses cin and returns to IDLE.
- Inputs are ignored on cycles where no word is accepted.

Test Plan:
- Single word, requester 0:
  - Stimulus: a=0x0000_0005, b=0x0000_0003, cin=1, last=1.
  - Required: one result, sum=0x0000_0009, cout=0, last=1, id=0, one cycle after acceptance.
- 3-word carry chain, requester 1, cin=0:
  - Stimulus: words (0xFFFF_FFFF,0x0000_0001), (0xFFFF_FFFF,0x0000_0000), (0x0000_0000,0x0000_0000,last).
  - Required sums: 0x0000_0000 cout=1, then 0x0000_0000 cout=1, then 0x0000_0001 cout=0 last=1, all with id=1.
- Contention:
  - Stimulus: both requesters hold 2-word transactions valid from reset.
  - Required: grant order 0,1,0,1. req1_ready stays 0 throughout requester 0's transaction. The carry never leaks across transactions.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles during a 4-word transaction.
  - Required: the owner's ready drops after the first word. res_sum, res_cout, res_last and res_id stay stable while stalled. No word is lost or duplicated after res_ready returns.
- Owner stall:
  - Stimulus: requester 0 drops valid after word 1 of 3, while requester 1 stays valid.
  - Required: the lock holds and req1_ready stays 0. The carry from word 1 is applied to word 2 when it arrives.
- Reset mid-transaction:
  - Stimulus: rst_n low for 1 cycle after word 1 of 3, with res_valid high.
  - Required: res_valid goes to 0 the next cycle. A fresh 1-word transaction uses its own cin and is granted to requester 0 if both are valid.

Source files
------------

// File: rtl/adder_mp_arbiter_if.sv
// Shared-adder handshake bundle: two word-streaming requesters
// and one registered, id-tagged result stream.
interface adder_mp_arbiter_if #(
    parameter int W = 32
);

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req0_last;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic         req1_last;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_last;
    logic         res_id;

    // Requesters and result consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_last,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_last,
        input  req1_ready,
        input  res_valid, res_sum, res_cout, res_last, res_id,
        output res_ready
    );

    // Arbitrated adder side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_last,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_last,
        output req1_ready,
        output res_valid, res_sum, res_cout, res_last, res_id,
        input  res_ready
    );

endinterface

// File: rtl/adder_mp_arbiter.sv
// Two-requester round-robin lock around one carry-select adder;
// multi-precision adds stream LS word first, carry chained per word.
module adder_mp_arbiter #(
    parameter int W = 32
) (
    input logic               clk,
    input logic               rst_n,
    adder_mp_arbiter_if.slave bus
);

    localparam int LW = W / 2;
    localparam int HW = W - LW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         owner;
    logic         ptr;
    logic         grant;
    logic         grant_id;

    logic         carry;
    logic         first_word;

    logic         res_valid_q;
    logic [W-1:0] res_sum_q;
    logic         res_cout_q;
    logic         res_last_q;
    logic         res_id_q;

    logic         rdy0;
    logic         rdy1;
    logic         any_valid;
    logic         both_valid;

    logic         sel_valid;
    logic         sel_ready;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic         sel_cin;
    logic         sel_last;
    logic         accept;
    logic         done;
    logic         cin_eff;

    logic [LW:0]  lo;
    logic [HW:0]  hi0;
    logic [HW:0]  hi1;
    logic [W-1:0] sum;
    logic         cout;

    assign any_valid  = bus.req0_valid | bus.req1_valid;
    assign both_valid = bus.req0_valid & bus.req1_valid;

    // Owner's word fields, valid only while locked in BUSY
    assign sel_valid = owner ? bus.req1_valid : bus.req0_valid;
    assign sel_a     = owner ? bus.req1_a     : bus.req0_a;
    assign sel_b     = owner ? bus.req1_b     : bus.req0_b;
    assign sel_cin   = owner ? bus.req1_cin   : bus.req0_cin;
    assign sel_last  = owner ? bus.req1_last  : bus.req0_last;
    assign sel_ready = owner ? rdy1 : rdy0;

    assign accept  = (state == BUSY) && sel_valid && sel_ready;
    assign done    = accept && sel_last;
    assign cin_eff = first_word ? sel_cin : carry;

    // Carry-select: low half ripples, high half precomputed for both carries
    assign lo  = {1'b0, sel_a[LW-1:0]} + {1'b0, sel_b[LW-1:0]}
               + {{LW{1'b0}}, cin_eff};
    assign hi0 = {1'b0, sel_a[W-1:LW]} + {1'b0, sel_b[W-1:LW]};
    assign hi1 = {1'b0, sel_a[W-1:LW]} + {1'b0, sel_b[W-1:LW]}
               + {{HW{1'b0}}, 1'b1};
    assign sum  = {(lo[LW] ? hi1[HW-1:0] : hi0[HW-1:0]), lo[LW-1:0]};
    assign cout = lo[LW] ? hi1[HW] : hi0[HW];

    // State register, owner latch and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) owner <= grant_id;
            if (done)  ptr   <= ~owner;
        end
    end

    // Next-state and arbitration decision
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_id = ptr;
        unique case (state)
            IDLE: begin
                if (any_valid) state_nx = ARB;
            end
            ARB: begin
                if (any_valid) begin
                    grant    = 1'b1;
                    grant_id = both_valid ? ptr : bus.req1_valid;
                    state_nx = BUSY;
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Readies: only the owner may advance, and only if the result slot frees
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (state == BUSY) begin
            rdy0 = !owner && (!res_valid_q || bus.res_ready);
            rdy1 =  owner && (!res_valid_q || bus.res_ready);
        end
    end

    // Carry chain state and registered result slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry       <= 1'b0;
            first_word  <= 1'b1;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_last_q  <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            if (accept) begin
                res_valid_q <= 1'b1;
                res_sum_q   <= sum;
                res_cout_q  <= cout;
                res_last_q  <= sel_last;
                res_id_q    <= owner;
                carry       <= sel_last ? 1'b0 : cout;
                first_word  <= sel_last;
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (grant) first_word <= 1'b1;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_sum    = res_sum_q;
    assign bus.res_cout   = res_cout_q;
    assign bus.res_last   = res_last_q;
    assign bus.res_id     = res_id_q;

endmodule

// File: tb/tb_adder_mp_arbiter.sv
// Directed bench for adder_mp_arbiter: hand-computed result
// records compared in order against the observed result stream.
module tb_adder_mp_arbiter;

    typedef logic [34:0] rec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   both_rdy;
    rec_t q[$];
    rec_t snap;

    adder_mp_arbiter_if #(.W(32)) bus ();

    adder_mp_arbiter #(.W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result word that is handed off downstream
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready)
            q.push_back({bus.res_id, bus.res_last, bus.res_cout, bus.res_sum});
        if (bus.req0_ready && bus.req1_ready)
            both_rdy++;
    end

    function automatic rec_t r(input logic id, last, cout, input logic [31:0] s);
        return {id, last, cout, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic id, input logic [31:0] a, b,
                       input logic cin, last);
        bit ok;
        ok = 1'b0;
        if (id) begin
            bus.req1_a = a; bus.req1_b = b;
            bus.req1_cin = cin; bus.req1_last = last;
            bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b;
            bus.req0_cin = cin; bus.req0_last = last;
            bus.req0_valid = 1'b1;
        end
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("put_timeout", 0, 1);
    endtask

    task automatic exp_res(input string tag, input rec_t e);
        rec_t g;
        for (int n = 0; n < 100 && q.size() == 0; n++) @(negedge clk);
        if (q.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            g = q.pop_front();
            chk(tag, g, e);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; both_rdy = 0;
        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req0_cin = 0; bus.req0_last = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0;
        bus.req1_cin = 0; bus.req1_last = 0;
        bus.res_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_rec", {bus.res_id, bus.res_last, bus.res_cout, bus.res_sum}, 0);
        chk("rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.res_ready = 1'b1;

        // Single word, requester 0, one-cycle latency
        put(0, 32'h5, 32'h3, 1, 1);
        bus.req0_valid = 0;
        chk("t1_latency", bus.res_valid, 1);
        exp_res("t1_res", r(0, 1, 0, 32'h9));

        // Three-word carry chain, requester 1; later cin ignored
        put(1, 32'hFFFF_FFFF, 32'h1, 0, 0);
        put(1, 32'hFFFF_FFFF, 32'h0, 1, 0);
        put(1, 32'h0, 32'h0, 1, 1);
        bus.req1_valid = 0;
        exp_res("t2_w0", r(1, 0, 1, 32'h0));
        exp_res("t2_w1", r(1, 0, 1, 32'h0));
        exp_res("t2_w2", r(1, 1, 0, 32'h1));

        // Contention from reset: grant order 0,1,0,1
        do_reset();
        fork
            begin
                put(0, 32'h1, 32'h2, 0, 0);
                put(0, 32'hFFFF_FFFF, 32'h1, 0, 1);
                put(0, 32'h100, 32'h200, 0, 0);
                put(0, 32'h7, 32'h8, 0, 1);
                bus.req0_valid = 0;
            end
            begin
                put(1, 32'h5, 32'h6, 0, 0);
                put(1, 32'h8000_0000, 32'h8000_0000, 0, 1);
                put(1, 32'h0, 32'h0, 1, 0);
                put(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
                bus.req1_valid = 0;
            end
        join
        exp_res("t3_a0", r(0, 0, 0, 32'h3));
        exp_res("t3_a1", r(0, 1, 1, 32'h0));
        exp_res("t3_b0", r(1, 0, 0, 32'hB));
        exp_res("t3_b1", r(1, 1, 1, 32'h0));
        exp_res("t3_c0", r(0, 0, 0, 32'h300));
        exp_res("t3_c1", r(0, 1, 0, 32'hF));
        exp_res("t3_d0", r(1, 0, 0, 32'h1));
        exp_res("t3_d1", r(1, 1, 1, 32'hFFFF_FFFE));
        chk("t3_both_ready", both_rdy, 0);

        // Backpressure during a four-word transaction
        @(posedge clk); #1;
        fork
            begin
                put(0, 32'h1, 32'h1, 1, 0);
                put(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
                put(0, 32'h0, 32'h0, 0, 0);
                put(0, 32'h2, 32'h3, 0, 1);
                bus.req0_valid = 0;
            end
            begin
                for (int n = 0; n < 50 && !bus.res_valid; n++) @(negedge clk);
                @(posedge clk); #1;
                bus.res_ready = 0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 0)
                        snap = {bus.res_id, bus.res_last, bus.res_cout, bus.res_sum};
                    chk("t4_stable",
                        {bus.res_valid, bus.res_id, bus.res_last, bus.res_cout, bus.res_sum},
                        {1'b1, r(0, 0, 1, 32'hFFFF_FFFE)});
                    chk("t4_rdy0", bus.req0_ready, 0);
                end
                chk("t4_snap", snap, r(0, 0, 1, 32'hFFFF_FFFE));
                @(posedge clk); #1;
                bus.res_ready = 1;
            end
        join
        exp_res("t4_w0", r(0, 0, 0, 32'h3));
        exp_res("t4_w1", r(0, 0, 1, 32'hFFFF_FFFE));
        exp_res("t4_w2", r(0, 0, 0, 32'h1));
        exp_res("t4_w3", r(0, 1, 0, 32'h5));

        // Owner stall: lock holds, carry survives the gap
        @(posedge clk); #1;
        put(0, 32'hFFFF_FFFF, 32'h0, 1, 0);
        bus.req0_valid = 0;
        bus.req1_a = 32'h10; bus.req1_b = 32'h10;
        bus.req1_cin = 1; bus.req1_last = 1;
        bus.req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_rdy1_locked", bus.req1_ready, 0);
        end
        @(posedge clk); #1;
        put(0, 32'h0, 32'h0, 0, 0);
        put(0, 32'h4, 32'h4, 0, 1);
        bus.req0_valid = 0;
        put(1, 32'h10, 32'h10, 1, 1);
        bus.req1_valid = 0;
        exp_res("t5_w0", r(0, 0, 1, 32'h0));
        exp_res("t5_w1", r(0, 0, 0, 32'h1));
        exp_res("t5_w2", r(0, 1, 0, 32'h8));
        exp_res("t5_r1", r(1, 1, 0, 32'h21));

        // Reset mid-transaction: pointer, carry and result slot cleared
        @(posedge clk); #1;
        put(0, 32'h2, 32'h2, 0, 1);
        bus.req0_valid = 0;
        exp_res("t6_pre", r(0, 1, 0, 32'h4));
        @(posedge clk); #1;
        bus.res_ready = 0;
        put(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        chk("t6_held_valid", bus.res_valid, 1);
        bus.req0_a = 32'h100; bus.req0_b = 32'h1;
        bus.req0_cin = 0; bus.req0_last = 1;
        bus.req0_valid = 1;
        bus.req1_a = 32'h200; bus.req1_b = 32'h2;
        bus.req1_cin = 0; bus.req1_last = 1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("t6_rst_valid", bus.res_valid, 0);
        chk("t6_rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
        chk("t6_no_output", q.size(), 0);
        bus.res_ready = 1;
        put(0, 32'h100, 32'h1, 0, 1);
        bus.req0_valid = 0;
        put(1, 32'h200, 32'h2, 0, 1);
        bus.req1_valid = 0;
        exp_res("t6_r0", r(0, 1, 0, 32'h101));
        exp_res("t6_r1", r(1, 1, 0, 32'h202));

        repeat (5) @(negedge clk);
        chk("no_extra", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
